oam_dma_arbiter_mod: RTL and testbench

//  Owns the single system memory bus and shares it between CPU data accesses and the OAM DMA engine.
//  A CPU write to DMA_REG_ADDR starts a DMA_LEN-byte copy from {page,8'h00} to DEST_BASE.

---
 rtl/oam_dma_arbiter_mod.sv | 158 +++++++++++++++
 tb/tb_oam_dma_arbiter_mod.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter_mod.sv
// Single-bus arbiter between CPU data accesses and the OAM DMA engine.
// A CPU write to DMA_REG_ADDR starts a DMA_LEN-byte copy into OAM; only HRAM stays reachable meanwhile.
module oam_dma_arbiter_mod #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int unsigned DMA_LEN      = 160,
  parameter int unsigned START_DELAY  = 1,
  parameter logic [15:0] HRAM_LO      = 16'hFF80,
  parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [7:0]  cpu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        dma_active_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} state_t;

  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [7:0] DELAY_INIT = 8'(START_DELAY - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] delay_q, delay_d;
  logic       fair_q, fair_d;
  logic       rd_sel_q, rd_sel_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rdata_q;
  logic       block_q;

  logic       blocked;
  logic       cpu_hram;
  logic       cpu_dma_reg;
  logic       cpu_pass;
  logic [7:0] eff_page;

  // Outputs are forced quiet during reset and the cycle that follows it.
  assign blocked      = reset | block_q;
  assign cpu_hram     = (cpu_addr_i >= HRAM_LO) && (cpu_addr_i <= HRAM_HI);
  assign cpu_dma_reg  = (cpu_addr_i == DMA_REG_ADDR);
  assign eff_page     = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
  assign dma_active_o = !blocked && (state_q != S_IDLE);
  assign cpu_rdata_o  = rd_valid_q ? (rd_sel_q ? page_q : mem_rdata_i) : rdata_q;

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    idx_d       = idx_q;
    delay_d     = delay_q;
    fair_d      = fair_q;
    rd_sel_d    = rd_sel_q;
    rd_valid_d  = 1'b0;
    cpu_pass    = 1'b0;
    cpu_ack_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 16'h0000;
    mem_wdata_o = 8'h00;

    if (!blocked) begin
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req_i) begin
            cpu_ack_o = 1'b1;
            if (cpu_dma_reg) begin
              if (cpu_we_i) begin
                page_d  = cpu_wdata_i;
                idx_d   = 8'h00;
                delay_d = DELAY_INIT;
                state_d = S_START;
              end else begin
                rd_valid_d = 1'b1;
                rd_sel_d   = 1'b1;
              end
            end else begin
              cpu_pass = 1'b1;
            end
          end
        end
        S_START: begin
          if (delay_q == 8'h00) state_d = S_READ;
          else                  delay_d = delay_q - 8'h01;
        end
        S_READ: begin
          // fair_q forces at least one DMA byte between consecutive CPU grants.
          if (cpu_req_i && cpu_hram && !fair_q) begin
            cpu_ack_o = 1'b1;
            cpu_pass  = 1'b1;
            fair_d    = 1'b1;
          end else begin
            mem_req_o  = 1'b1;
            mem_addr_o = {eff_page, idx_q};
            state_d    = S_WRITE;
          end
        end
        S_WRITE: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = DEST_BASE + {8'h00, idx_q};
          mem_wdata_o = mem_rdata_i;
          fair_d      = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (cpu_pass) begin
        mem_req_o   = 1'b1;
        mem_we_o    = cpu_we_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        rd_valid_d  = !cpu_we_i;
        rd_sel_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      delay_q    <= 8'h00;
      fair_q     <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= 8'h00;
      block_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      delay_q    <= delay_d;
      fair_q     <= fair_d;
      rd_sel_q   <= rd_sel_d;
      rd_valid_q <= rd_valid_d;
      rdata_q    <= cpu_rdata_o;
      block_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter_mod.sv
// Self-checking bench for oam_dma_arbiter_mod: vector table for plain accesses,
// hand sequences for DMA runs, read data checked through a scoreboard queue.
module tb_oam_dma_arbiter_mod;

  localparam int START_DELAY = 1;
  localparam int DMA_LEN     = 160;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  oam_dma_arbiter_mod dut (
    .clock(clock), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .dma_active_o(dma_active)
  );

  always #5 clock = ~clock;

  // Memory model: contents start as a function of address, registered read data.
  logic [7:0] mem [0:65535];
  bit         mem_init = 1'b0;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'hC000)         return 8'h5A;
    else if (a[15:8] == 8'hC1) return a[7:0];
    else                       return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_val(16'(a));
      mem_init  <= 1'b1;
      mem_rdata <= 8'h00;
    end else if (mem_req) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rd_q[$];
  logic       rd_pend = 1'b0;
  logic [7:0] rd_expect = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called once per cycle at the falling edge: settles last cycle's read, queues this one.
  task automatic sample();
    logic [7:0] e;
    @(negedge clock);
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rdata_queue: read acked with nothing expected, got %0h", cpu_rdata);
      end else begin
        e = rd_q.pop_front();
        chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e});
      end
    end
    rd_pend = cpu_ack && cpu_req && !cpu_we;
    if (rd_pend) rd_q.push_back(rd_expect);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic trigger(input logic [7:0] page);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = page;
    sample();
    chk("trig_ack", {31'h0, cpu_ack}, 32'd1);
    chk("trig_mem_req", {31'h0, mem_req}, 32'd0);
    next();
    cpu_req = 1'b0;
    $display("dma trigger page=%02h", page);
  endtask

  task automatic oam_check(input string name, input logic [7:0] xor_v, input int upto,
                           input logic [7:0] xor_rest);
    int errs = 0;
    logic [7:0] e;
    for (int i = 0; i < DMA_LEN; i++) begin
      e = (i < upto) ? (8'(i) ^ xor_v) : (8'(i) ^ xor_rest);
      if (mem[16'hFE00 + 16'(i)] !== e) errs++;
    end
    chk(name, errs, 0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_mreq;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, grants, last, stray, cyc;
    logic [15:0] first_rd;
    logic        seen;

    vecs[0] = '{1'b0, 16'hC000, 8'h00, 1'b1, 8'h5A};
    vecs[1] = '{1'b1, 16'hC010, 8'h33, 1'b1, 8'h00};
    vecs[2] = '{1'b0, 16'hC010, 8'h00, 1'b1, 8'h33};
    vecs[3] = '{1'b0, 16'hFF46, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 16'hFF90, 8'h00, 1'b1, 8'h6F};
    vecs[5] = '{1'b1, 16'hFF80, 8'hA5, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 16'hFF80, 8'h00, 1'b1, 8'hA5};

    // Reset with a request pending: everything quiet during reset and the cycle after.
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000; cpu_wdata = 8'h00;
    rd_expect = 8'h5A;
    next(); next();
    sample();
    chk("rst_ack", {31'h0, cpu_ack}, 32'd0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst_dma_active", {31'h0, dma_active}, 32'd0);
    chk("rst_rdata", {24'h0, cpu_rdata}, 32'h0);
    next();
    reset = 1'b0;
    sample();
    chk("post_rst_ack", {31'h0, cpu_ack}, 32'd0);
    chk("post_rst_mem_req", {31'h0, mem_req}, 32'd0);
    next();

    // Plain accesses in IDLE.
    foreach (vecs[k]) begin
      cpu_req = 1'b1; cpu_we = vecs[k].we; cpu_addr = vecs[k].addr; cpu_wdata = vecs[k].wdata;
      rd_expect = vecs[k].exp_rd;
      sample();
      chk("vec_ack", {31'h0, cpu_ack}, 32'd1);
      chk("vec_mem_req", {31'h0, mem_req}, {31'h0, vecs[k].exp_mreq});
      if (vecs[k].exp_mreq) begin
        chk("vec_mem_we", {31'h0, mem_we}, {31'h0, vecs[k].we});
        chk("vec_mem_addr", {16'h0, mem_addr}, {16'h0, vecs[k].addr});
        if (vecs[k].we) chk("vec_mem_wdata", {24'h0, mem_wdata}, {24'h0, vecs[k].wdata});
      end
      chk("vec_dma_active", {31'h0, dma_active}, 32'd0);
      $display("vec %0d we=%0d addr=%04h ack=%0d mem_req=%0d", k, vecs[k].we, vecs[k].addr,
               cpu_ack, mem_req);
      next();
    end
    cpu_req = 1'b0;
    sample();
    next();

    // Plain DMA copy from page C1.
    trigger(8'hC1);
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      sample();
      if (!dma_active) break;
      n++;
      next();
    end
    chk("dma_len", n, START_DELAY + 2 * DMA_LEN);
    oam_check("oam_c1", 8'h00, DMA_LEN, 8'h00);
    $display("dma page=c1 active_cycles=%0d", n);
    next();

    // Read back the latched page.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF46; rd_expect = 8'hC1;
    sample();
    chk("ff46_ack", {31'h0, cpu_ack}, 32'd1);
    chk("ff46_mem_req", {31'h0, mem_req}, 32'd0);
    next();
    cpu_req = 1'b0;
    sample();
    $display("read ff46 rdata=%02h", cpu_rdata);
    next();

    // Held HRAM read during DMA: one grant per byte, spaced by three cycles.
    trigger(8'hC2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF90; rd_expect = 8'h6F;
    n = 0; grants = 0; last = -1; stray = 0;
    for (int c = 0; c < 3000; c++) begin
      sample();
      if (!dma_active) break;
      n++;
      if (cpu_ack) begin
        grants++;
        if (mem_addr !== 16'hFF90 || mem_we !== 1'b0) stray++;
        if (last >= 0 && c - last != 3) stray++;
        last = c;
      end
      next();
    end
    chk("hram_grants", grants, DMA_LEN);
    chk("hram_grant_shape", stray, 0);
    chk("hram_dma_len", n, START_DELAY + 3 * DMA_LEN);
    chk("hram_idle_ack", {31'h0, cpu_ack}, 32'd1);
    next();
    cpu_req = 1'b0;
    sample();
    oam_check("oam_c2", 8'hC2, DMA_LEN, 8'hC2);
    $display("dma page=c2 with hram reads grants=%0d active_cycles=%0d", grants, n);
    next();

    // Non-HRAM write during DMA waits for IDLE.
    trigger(8'hC1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'h9C;
    n = 0; stray = 0;
    for (int c = 0; c < 2000; c++) begin
      sample();
      if (!dma_active) break;
      n++;
      if (cpu_ack) stray++;
      if (mem_we && mem_addr == 16'hC000) stray++;
      next();
    end
    chk("stall_no_grant", stray, 0);
    chk("stall_dma_len", n, START_DELAY + 2 * DMA_LEN);
    chk("stall_ack", {31'h0, cpu_ack}, 32'd1);
    chk("stall_mem_we", {31'h0, mem_we}, 32'd1);
    chk("stall_mem_addr", {16'h0, mem_addr}, 32'h0000C000);
    chk("stall_mem_wdata", {24'h0, mem_wdata}, 32'h9C);
    next();
    cpu_req = 1'b0;
    sample();
    chk("stall_mem_c000", {24'h0, mem[16'hC000]}, 32'h9C);
    $display("cpu write c000 during dma acked after %0d cycles", n);
    next();

    // Echo page redirect, then reset in the middle of the copy.
    trigger(8'hE3);
    seen = 1'b0; first_rd = 16'h0000; cyc = 0;
    for (int c = 0; c < 2000; c++) begin
      sample();
      if (mem_req && !mem_we && !seen) begin
        first_rd = mem_addr;
        seen = 1'b1;
      end
      if (mem_req && !mem_we && mem_addr == 16'hC332) break;
      cyc++;
      next();
    end
    chk("echo_first_read", {16'h0, first_rd}, 32'h0000C300);
    chk("echo_reach_idx50", {31'h0, mem_req && !mem_we && mem_addr == 16'hC332}, 32'd1);
    next();
    reset = 1'b1;
    sample();
    chk("midrst_mem_req", {31'h0, mem_req}, 32'd0);
    chk("midrst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("midrst_dma_active", {31'h0, dma_active}, 32'd0);
    next();
    reset = 1'b0;
    rd_pend = 1'b0;
    sample();
    chk("after_rst_dma_active", {31'h0, dma_active}, 32'd0);
    chk("after_rst_mem_req", {31'h0, mem_req}, 32'd0);
    next();
    sample();
    chk("idle_dma_active", {31'h0, dma_active}, 32'd0);
    chk("idle_mem_req", {31'h0, mem_req}, 32'd0);
    oam_check("oam_partial", 8'hC3, 50, 8'h00);
    $display("dma page=e3 reset at idx 50 after %0d cycles", cyc);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
